// File: rtl/pulse_stretcher_pkg.sv
// Shared FSM state encoding and counter sizing for pulse_stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_GAP    = 2'b10
  } state_t;

  // One counter serves both phases, so it must hold the larger of the two reloads.
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Tick request and stretched-level status bundle; master drives tick, slave answers.
interface pulse_stretcher_if;
  logic tick;
  logic out;
  logic busy;
  logic done;
  logic missed;

  modport master (output tick, input out, busy, done, missed);
  modport slave  (input tick, output out, busy, done, missed);
endinterface

// File: rtl/pulse_stretcher_down_counter_ld.sv
// Loadable down counter with zero flag; load wins over decrement, holds at zero.
// One-cycle update, no backpressure.
module down_counter_ld #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a tick into a WIDTH-cycle level plus GAP-cycle guard; out rises 1 cycle after the tick.
// No backpressure: ticks while busy are dropped and flagged on missed (PULSE_STRETCHER_RETRIGGER_EN lets ACTIVE ticks reload).
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic                clk,
  input  logic                reset,
  pulse_stretcher_if.slave    bus
);

  localparam int            CW       = cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] WIDTH_LD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LD   = (GAP > 0) ? CW'(GAP - 1) : '0;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] count;
  logic          cnt_zero;
  logic          cnt_ld;
  logic          cnt_dec;
  logic [CW-1:0] cnt_val;
  logic          out_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          missed_reg;

  always_comb begin
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = WIDTH_LD;
    case (state)
      ST_IDLE: cnt_ld = bus.tick;
      ST_ACTIVE: begin
        if (RETRIG && bus.tick) begin
          cnt_ld = 1'b1;
        end else if (cnt_zero) begin
          cnt_ld  = (GAP > 0);
          cnt_val = GAP_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_GAP: cnt_dec = !cnt_zero;
      default: begin
        cnt_ld  = 1'b1;
        cnt_val = '0;
      end
    endcase
  end

  down_counter_ld #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_ld),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (count),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      out_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      missed_reg <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      missed_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.tick) begin
            state    <= ST_ACTIVE;
            out_reg  <= 1'b1;
            busy_reg <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          // A retrigger on the final edge keeps the pulse alive and suppresses done.
          if (!(RETRIG && bus.tick)) begin
            missed_reg <= bus.tick;
            if (cnt_zero) begin
              out_reg  <= 1'b0;
              done_reg <= 1'b1;
              if (GAP > 0) begin
                state <= ST_GAP;
              end else begin
                state    <= ST_IDLE;
                busy_reg <= 1'b0;
              end
            end
          end
        end
        ST_GAP: begin
          missed_reg <= bus.tick;
          if (cnt_zero) begin
            state    <= ST_IDLE;
            busy_reg <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          out_reg  <= 1'b0;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out    = out_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.missed = missed_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scoreboard bench: unit 0 is WIDTH=4/GAP=2, unit 1 is WIDTH=1/GAP=0; vectors are {out,busy,done,missed}.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         unit;
    int         cyc;
    string      tag;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];

  pulse_stretcher_if ifa ();
  pulse_stretcher_if ifb ();

  pulse_stretcher #(.WIDTH(4), .GAP(2)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  pulse_stretcher #(.WIDTH(1), .GAP(0)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] obs(input int unit);
    if (unit == 0) return {ifa.out, ifa.busy, ifa.done, ifa.missed};
    return {ifb.out, ifb.busy, ifb.done, ifb.missed};
  endfunction

  task automatic check(input string tag, input logic [3:0] o, input logic [3:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask

  task automatic push(input int unit, input string tag, input int c0, input int c1,
                      input logic [3:0] v);
    for (int c = c0; c <= c1; c++) sb.push_back('{unit, c, tag, v});
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].tag, obs(sb[i].unit), sb[i].v);
        sb.delete(i);
      end
    end
  end

  initial begin
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    ifa.tick = 1'b0;
    ifb.tick = 1'b0;

    goto(2);
    check("reset_a", obs(0), 4'b0000);
    check("reset_b", obs(1), 4'b0000);
    goto(3);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Single pulse, then tick held high across both GAP cycles into IDLE.
    push(0, "idle",       10, 10, 4'b0000);
    push(0, "pulse",      11, 14, 4'b1100);
    push(0, "done",       15, 15, 4'b0110);
    push(0, "gap_miss",   16, 16, 4'b0101);
    push(0, "gap_end",    17, 17, 4'b0001);
    push(0, "reaccept",   18, 21, 4'b1100);
    push(0, "re_done",    22, 22, 4'b0110);
    push(0, "re_gap",     23, 23, 4'b0100);
    push(0, "re_idle",    24, 24, 4'b0000);
    goto(10); ifa.tick = 1'b1;
    goto(11); ifa.tick = 1'b0;
    goto(15); ifa.tick = 1'b1;
    goto(18); ifa.tick = 1'b0;

    // Second tick two cycles into the pulse.
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    push(0, "rt_pulse",   31, 36, 4'b1100);
    push(0, "rt_done",    37, 37, 4'b0110);
    push(0, "rt_gap",     38, 38, 4'b0100);
    push(0, "rt_idle",    39, 39, 4'b0000);
`else
    push(0, "act_pulse",  31, 32, 4'b1100);
    push(0, "act_miss",   33, 33, 4'b1101);
    push(0, "act_pulse2", 34, 34, 4'b1100);
    push(0, "act_done",   35, 35, 4'b0110);
    push(0, "act_gap",    36, 36, 4'b0100);
    push(0, "act_idle",   37, 37, 4'b0000);
`endif
    goto(30); ifa.tick = 1'b1;
    goto(31); ifa.tick = 1'b0;
    goto(32); ifa.tick = 1'b1;
    goto(33); ifa.tick = 1'b0;

    // Asynchronous reset in the middle of a pulse, then a fresh pulse.
    push(0, "pre_rst",    51, 51, 4'b1100);
    goto(50); ifa.tick = 1'b1;
    goto(51); ifa.tick = 1'b0;
    goto(52);
    check("mid_pulse", obs(0), 4'b1100);
    rst_a = 1'b0;
    #1;
    check("async_rst", obs(0), 4'b0000);
    push(0, "in_rst",     52, 54, 4'b0000);
    goto(54); rst_a = 1'b1;
    push(0, "post_rst",   55, 58, 4'b0000);
    push(0, "fresh",      59, 62, 4'b1100);
    push(0, "fresh_done", 63, 63, 4'b0110);
    push(0, "fresh_gap",  64, 64, 4'b0100);
    push(0, "fresh_idle", 65, 65, 4'b0000);
    goto(58); ifa.tick = 1'b1;
    goto(59); ifa.tick = 1'b0;

    // WIDTH=1, GAP=0 with tick held for three cycles.
    push(1, "w1_idle",    70, 70, 4'b0000);
    push(1, "w1_pulse",   71, 71, 4'b1100);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    push(1, "w1_retrig",  72, 73, 4'b1100);
`else
    push(1, "w1_miss",    72, 72, 4'b0011);
    push(1, "w1_again",   73, 73, 4'b1100);
`endif
    push(1, "w1_done",    74, 74, 4'b0010);
    push(1, "w1_end",     75, 75, 4'b0000);
    goto(70); ifb.tick = 1'b1;
    goto(73); ifb.tick = 1'b0;

    goto(80);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts a single-cycle tick, such as an edge-detect strobe or a game-event strobe, into a clean level of fixed length.
- Then enforces a low guard interval before another tick is accepted.
- Drives level-sensitive consumers (LED flash, brick-hit sound enable, paddle freeze) from tick-domain logic in the brick-smasher datapath.
- Reports completion and dropped ticks.

Parameters:
- WIDTH, 8, cycles `out` stays high per accepted tick; legal range ≥1.
- GAP, 2, guard cycles with `out` low after each pulse; legal range ≥0. 0 = return straight to IDLE.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- tick  input  1  single-cycle request strobe, synchronous to clk.
- out  output  1  stretched level, registered.
- busy  output  1  high while in ACTIVE or GAP, registered.
- done  output  1  one-cycle strobe in the first cycle after `out` falls.
- missed  output  1  one-cycle strobe, registered, when a tick is rejected.

Behaviour:
- Reset: when `reset`=0, state=IDLE, count=0, and out/busy/done/missed=0 immediately, whatever the clock. This also applies mid-pulse: `out` drops with no `done`.
- State machine:
  - IDLE: `tick`=1 at an edge → ACTIVE, count←WIDTH-1, `out`=1 from the next cycle.
  - ACTIVE: if count≠0, count decrements. If count=0 at an edge:
    - `out`←0 and `done`←1 for one cycle.
    - If GAP>0: → GAP, count←GAP-1.
    - If GAP=0: → IDLE.
  - GAP: `out` stays 0. If count≠0, decrement; if count=0 → IDLE.
- Timing:
  - Latency from the accepting edge to `out` rising is 1 cycle.
  - `out` stays high for exactly WIDTH cycles.
  - `busy` stays high for WIDTH+GAP cycles.
- Rejected ticks:
  - A tick in ACTIVE is dropped (unless the optional feature is enabled) and `missed`=1 on the next cycle.
  - A tick in GAP, including the final GAP cycle, is always dropped with `missed`=1.
- No queuing. A tick with GAP=0 on the edge where ACTIVE ends is dropped, not chained.
- `tick` held high for several cycles is treated as one tick per cycle. Each cycle is evaluated independently, so a level input yields repeated `missed` strobes.
- Counter width is clog2(max(WIDTH,GAP)+1) bits. Counting is down only, with no wrap; count never decrements below 0.
- Illegal state encodings → IDLE on the next edge, with `out`=0.

Optional Feature:
- Macro: PULSE_STRETCHER_RETRIGGER_EN.
- Defined:
  - A tick in ACTIVE reloads count←WIDTH-1 with `out` staying high, and does not raise `missed`.
  - A retrigger on the count=0 edge wins: no `done`, and the pulse extends.
  - A tick in GAP is still rejected with `missed`.
- Undefined: a tick in ACTIVE is rejected as described in Behaviour.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'b00, ACTIVE=2'b01, GAP=2'b10, matching the team's 2-bit FSM encoding style.
  - The clog2-based counter-width function.
- One natural sub-module: `down_counter_ld`, a loadable down counter with a zero flag, reused for ACTIVE and GAP.
- FSM and output registers stay in the top module.

Test Plan:
- WIDTH=4, GAP=2, reset released:
  - tick at cycle 10 → `out`=1 for cycles 11–14, `done`=1 at cycle 15.
  - `busy`=1 for cycles 11–16; a new tick is accepted at cycle 17.
- WIDTH=4, GAP=2, ticks at cycles 10 and 12 (feature off) → second tick raises `missed` at cycle 13; `out` is unchanged (high through 14).
- Same stimulus with PULSE_STRETCHER_RETRIGGER_EN → `out` high for cycles 11–16, `done` at 17, no `missed`.
- Tick during GAP (cycle 15 or 16) → `missed`=1 next cycle, `out` stays 0; a tick at 17 is accepted.
- Reset pulled low at cycle 12 mid-pulse → out/busy/done/missed=0 asynchronously before the next edge; after release, IDLE and a fresh tick behave normally.
- WIDTH=1, GAP=0, tick at cycle 5 → `out`=1 only at cycle 6, `done`=1 at 7; a tick at 6 is missed, a tick at 7 is accepted (`out`=1 at 8).
